// File: rtl/mont_mul.sv
// Radix-2 bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod m.
// One start produces one multiplication of WIDTH loop iterations.
// Optional build macro MONT_FINAL_SUB_EN adds the final conditional
// subtraction state (fully reduced result, one extra cycle of latency).
// Without it the raw accumulator (< 2m) is returned straight from the loop.
module mont_mul #(
  parameter int unsigned WIDTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOP
`ifdef MONT_FINAL_SUB_EN
    , S_SUB
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH+1:0] c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             done_q, done_d;

  // One Montgomery iteration: add b if the current a bit is set, then add m
  // if needed to make the sum even, then halve.
  logic [WIDTH+1:0] t1, t2, c_next;

  always_comb begin
    t1     = c_q + (a_q[0] ? {2'b00, b_q} : '0);
    t2     = t1 + (t1[0] ? {2'b00, m_q} : '0);
    c_next = t2 >> 1;
  end

`ifdef MONT_FINAL_SUB_EN
  // Final reduction: C < 2m < 2^(WIDTH+1), so WIDTH+1 bits hold the difference.
  logic           c_ge_m;
  logic [WIDTH:0] c_sub;

  always_comb begin
    c_ge_m = (c_q >= {2'b00, m_q});
    c_sub  = c_q[WIDTH:0] - {1'b0, m_q};
  end
`endif

  // Next-state and datapath update for the control FSM.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = in_b;
          m_d     = in_m;
          c_d     = '0;
          cnt_d   = '0;
          state_d = S_LOOP;
        end
      end
      S_LOOP: begin
        c_d   = c_next;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
`ifdef MONT_FINAL_SUB_EN
          state_d = S_SUB;
`else
          // No reduction stage: the last iteration publishes the raw sum.
          state_d  = S_IDLE;
          result_d = c_next[WIDTH:0];
          done_d   = 1'b1;
`endif
        end
      end
`ifdef MONT_FINAL_SUB_EN
      S_SUB: begin
        result_d = c_ge_m ? c_sub : c_q[WIDTH:0];
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mont_mul.sv
// Self-checking bench for mont_mul: an 8-bit instance for directed and
// random tests, and a 1024-bit instance for wide random tests.
module tb_mont_mul;

`ifdef MONT_FINAL_SUB_EN
  localparam bit FSUB = 1'b1;
`else
  localparam bit FSUB = 1'b0;
`endif
  localparam int unsigned L8  = FSUB ? 9 : 8;
  localparam int unsigned L1K = FSUB ? 1025 : 1024;

  logic clk = 1'b0;
  logic rst;

  logic         s8, busy8, done8;
  logic [7:0]   a8, b8, m8;
  logic [8:0]   r8;
  logic         s1k, busy1k, done1k;
  logic [1023:0] a1k, b1k, m1k;
  logic [1024:0] r1k;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mont_mul #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst), .start(s8),
    .in_a(a8), .in_b(b8), .in_m(m8),
    .busy(busy8), .done(done8), .result(r8)
  );

  mont_mul #(.WIDTH(1024)) u1k (
    .clk(clk), .reset(rst), .start(s1k),
    .in_a(a1k), .in_b(b1k), .in_m(m1k),
    .busy(busy1k), .done(done1k), .result(r1k)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [7:0] exp;
  } vec_t;

  // Reference: reduce a*b mod m, then divide by 2 modulo m, w times.
  function automatic logic [1023:0] mont_ref(input logic [1023:0] a, input logic [1023:0] b,
                                             input logic [1023:0] m, input int unsigned w);
    logic [2047:0] p;
    logic [1024:0] x;
    p = ({1024'b0, a} * {1024'b0, b}) % {1024'b0, m};
    x = 1025'(p);
    for (int unsigned i = 0; i < w; i++)
      x = x[0] ? ((x + {1'b0, m}) >> 1) : (x >> 1);
    return x[1023:0];
  endfunction

  // Without the final subtraction the DUT may return C in [m, 2m); fold it once.
  function automatic logic [1024:0] norm(input logic [1024:0] r, input logic [1023:0] m);
    if (FSUB) return r;
    return (r >= {1'b0, m}) ? (r - {1'b0, m}) : r;
  endfunction

  task automatic chk(input string nm, input logic [1024:0] act, input logic [1024:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (low 64 bits)", nm, act[63:0], exp[63:0]);
    end
  endtask

  // One complete operation on the chosen instance with latency/handshake checks.
  task automatic run_op(input bit big, input logic [1023:0] a, input logic [1023:0] b,
                        input logic [1023:0] m, input logic [1023:0] exp, input string nm);
    int unsigned n;
    int unsigned lim;
    bit overlap;
    bit bz, dn;
    logic [1024:0] res;
    lim = (big ? L1K : L8) + 4;
    if (big) begin a1k = a; b1k = b; m1k = m; s1k = 1'b1; end
    else begin a8 = a[7:0]; b8 = b[7:0]; m8 = m[7:0]; s8 = 1'b1; end
    @(posedge clk); #1;
    s1k = 1'b0; s8 = 1'b0;
    bz = big ? busy1k : busy8;
    chk({nm, " busy_after_accept"}, 1025'(bz), 1025'(1));
    n = 0; overlap = 1'b0; dn = 1'b0;
    while (!dn && n < lim) begin
      @(posedge clk); #1;
      n++;
      dn = big ? done1k : done8;
      bz = big ? busy1k : busy8;
      if (dn && bz) overlap = 1'b1;
    end
    res = big ? r1k : {1016'b0, r8};
    chk({nm, " latency"}, 1025'(n), 1025'(big ? L1K : L8));
    chk({nm, " busy_done_overlap"}, 1025'(overlap), 1025'(0));
    chk({nm, " result"}, norm(res, m), {1'b0, exp});
    if (!big && FSUB) chk({nm, " result_msb"}, 1025'(res[8]), 1025'(0));
    @(posedge clk); #1;
    dn = big ? done1k : done8;
    chk({nm, " done_one_cycle"}, 1025'(dn), 1025'(0));
  endtask

  initial begin
    vec_t tv[5];
    logic [7:0] oa[3], ob[3], om[3];
    int unsigned tdone[3];
    logic [8:0] rdone[3];
    int unsigned dn;
    logic [1023:0] ra, rb, rm;

    tv[0] = '{a: 8'h11, b: 8'h05, m: 8'hEF, exp: 8'h05};
    tv[1] = '{a: 8'h32, b: 8'h01, m: 8'hEF, exp: 8'h11};
    tv[2] = '{a: 8'h00, b: 8'hEE, m: 8'hEF, exp: 8'h00};
    tv[3] = '{a: 8'h01, b: 8'h01, m: 8'hEF, exp: 8'hE1};
    tv[4] = '{a: 8'hEE, b: 8'hEE, m: 8'hEF, exp: 8'hE1};

    rst = 1'b1; s8 = 1'b0; s1k = 1'b0;
    a8 = '0; b8 = '0; m8 = '0; a1k = '0; b1k = '0; m1k = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy8", 1025'(busy8), 1025'(0));
    chk("reset done8", 1025'(done8), 1025'(0));
    chk("reset result8", {1016'b0, r8}, '0);
    chk("reset busy1k", 1025'(busy1k), 1025'(0));
    chk("reset result1k", r1k, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++)
      run_op(1'b0, 1024'(tv[i].a), 1024'(tv[i].b), 1024'(tv[i].m), 1024'(tv[i].exp),
             $sformatf("vec%0d", i));

    // Start held high across three operations; operands change mid-loop.
    oa[0] = 8'h11; ob[0] = 8'h05; om[0] = 8'hEF;
    oa[1] = 8'h32; ob[1] = 8'h77; om[1] = 8'hC5;
    oa[2] = 8'h9A; ob[2] = 8'h3C; om[2] = 8'hFB;
    a8 = oa[0]; b8 = ob[0]; m8 = om[0]; s8 = 1'b1;
    dn = 0;
    for (int unsigned i = 0; i <= 3 * L8 + 8; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        if (dn < 3) begin tdone[dn] = i; rdone[dn] = r8; end
        dn++;
      end
      if (i == 0) begin a8 = oa[1]; b8 = ob[1]; m8 = om[1]; end
      else if (i == L8 + 1) begin a8 = oa[2]; b8 = ob[2]; m8 = om[2]; end
      else if (i == 2 * L8 + 2) begin a8 = 8'h5A; b8 = 8'hA5; m8 = 8'h81; s8 = 1'b0; end
    end
    chk("b2b done_count", 1025'(dn), 1025'(3));
    for (int j = 0; j < 3; j++) begin
      if (j < int'(dn)) begin
        chk($sformatf("b2b%0d time", j), 1025'(tdone[j]), 1025'(j * (L8 + 1) + L8));
        chk($sformatf("b2b%0d result", j), norm({1016'b0, rdone[j]}, 1024'(om[j])),
            {1'b0, mont_ref(1024'(oa[j]), 1024'(ob[j]), 1024'(om[j]), 8)});
      end
    end

    // Reset at loop iteration 3 discards the operation.
    run_op(1'b0, 1024'(8'h11), 1024'(8'h05), 1024'(8'hEF), 1024'(8'h05), "pre_abort");
    a8 = 8'h32; b8 = 8'h55; m8 = 8'hEF; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 1025'(busy8), 1025'(0));
    chk("abort done", 1025'(done8), 1025'(0));
    chk("abort result", {1016'b0, r8}, '0);
    dn = 0;
    for (int unsigned i = 0; i < L8 + 6; i++) begin
      @(posedge clk); #1;
      if (done8) dn++;
    end
    chk("abort no_done", 1025'(dn), 1025'(0));
    run_op(1'b0, 1024'(8'h32), 1024'(8'h01), 1024'(8'hEF), 1024'(8'h11), "post_abort");

    // Random 8-bit operands.
    for (int i = 0; i < 40; i++) begin
      rm = 1024'($urandom_range(127, 1) * 2 + 1);
      ra = 1024'($urandom_range(int'(rm[7:0]) - 1, 0));
      rb = 1024'($urandom_range(int'(rm[7:0]) - 1, 0));
      run_op(1'b0, ra, rb, rm, mont_ref(ra, rb, rm, 8), $sformatf("rnd8_%0d", i));
    end

    // Random 1024-bit operands.
    for (int i = 0; i < 40; i++) begin
      for (int w = 0; w < 32; w++) begin
        rm[w*32 +: 32] = $urandom;
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      rm[1023] = 1'b1;
      rm[0] = 1'b1;
      ra = ra % rm;
      rb = rb % rm;
      run_op(1'b1, ra, rb, rm, mont_ref(ra, rb, rm, 1024), $sformatf("rnd1k_%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
